// File: rtl/gb_timer_pkg.sv
// Shared definitions for the GameBoy DIV/TIMA/TMA/TAC timer and the CGB KEY1 register.
package gb_timer_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_KEY1 = 16'hFF4D;

    typedef enum logic [1:0] {
        IDLE,
        OVF,
        RELOAD
    } tima_state_e;

    // System counter bit watched by TIMA for each TAC frequency setting.
    function automatic logic [2:0] tac_tap(input logic [1:0] freq);
        logic [2:0] tap;
        case (freq)
            2'b00:   tap = 3'd7;
            2'b01:   tap = 3'd1;
            2'b10:   tap = 3'd3;
            default: tap = 3'd5;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/gb_timer_edge.sv
// Registered falling-edge detector; while hold is high the history flop freezes
// and no edge is reported.
module gb_timer_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic hold,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else if (!hold) begin
            prev <= d;
        end
    end

    assign fall = prev & ~d & ~hold;

endmodule

// File: rtl/gb_timer_cgb.sv
// DIV/TIMA/TMA/TAC timer with the one-M-cycle overflow/reload window, plus the
// CGB KEY1 speed switch that fires on the STOP rising edge.
module gb_timer_cgb
    import gb_timer_pkg::*;
#(
    parameter int CNT_W    = 14,
    parameter bit CGB_MODE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic [15:0] addr,
    input  logic        wren,
    input  logic        stop_i,
    output logic [7:0]  data_o,
    output logic        irq_timer,
    output logic        double_speed
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt;
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    logic             prepare;
    logic             speed;
    logic             irq;
    tima_state_e      state;

    logic       wr_div, wr_tima, wr_tma, wr_tac, wr_key1;
    logic [7:0] tap_bits;
    logic       tick_in, inc;
    logic       stop_n, stop_rise, speed_switch;

    assign wr_div  = wren && (addr == ADDR_DIV);
    assign wr_tima = wren && (addr == ADDR_TIMA);
    assign wr_tma  = wren && (addr == ADDR_TMA);
    assign wr_tac  = wren && (addr == ADDR_TAC);
    assign wr_key1 = wren && (addr == ADDR_KEY1);

    assign tap_bits = cnt[7:0];
    assign tick_in  = tap_bits[tac_tap(tac[1:0])] & tac[2];

    // TIMA history freezes with the counter so leaving STOP cannot fake an edge.
    gb_timer_edge u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .d     (tick_in),
        .hold  (stop_i),
        .fall  (inc)
    );

    // A falling edge of the inverted level is the STOP entry edge.
    assign stop_n = ~stop_i;

    gb_timer_edge u_stop_edge (
        .clk   (clk),
        .reset (reset),
        .d     (stop_n),
        .hold  (1'b0),
        .fall  (stop_rise)
    );

    assign speed_switch = CGB_MODE && stop_rise && prepare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_div || speed_switch) begin
            cnt <= '0;
        end else if (!stop_i) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tma <= 8'h00;
            tac <= 3'b000;
        end else begin
            if (wr_tma) tma <= data_i;
            if (wr_tac) tac <= data_i[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prepare <= 1'b0;
            speed   <= 1'b0;
        end else if (speed_switch) begin
            speed   <= ~speed;
            prepare <= 1'b0;
        end else if (CGB_MODE && wr_key1) begin
            prepare <= data_i[0];
        end
    end

    // TIMA reload FSM. The TMA value lands in TIMA on the edge leaving OVF, so the
    // RELOAD cycle is the one where TIMA already shows TMA and irq is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tima  <= 8'h00;
            irq   <= 1'b0;
        end else begin
            irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_tima) begin
                        tima <= data_i;
                    end else if (inc) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            state <= OVF;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    if (wr_tima) begin
                        tima  <= data_i;
                        state <= IDLE;
                    end else begin
                        tima  <= wr_tma ? data_i : tma;
                        irq   <= 1'b1;
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    if (wr_tma) tima <= data_i;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_o = 8'hFF;
        case (addr)
            ADDR_DIV:  data_o = cnt[CNT_W-1 -: 8];
            ADDR_TIMA: data_o = tima;
            ADDR_TMA:  data_o = tma;
            ADDR_TAC:  data_o = {5'h1F, tac};
            ADDR_KEY1: data_o = CGB_MODE ? {speed, 6'h3F, prepare} : 8'hFF;
            default:   data_o = 8'hFF;
        endcase
    end

    assign irq_timer    = irq;
    assign double_speed = speed;

endmodule

// File: doc/gb_timer_cgb.md
# gb_timer_cgb

Parametrised successor timer for the GameBoy SoC, serving both DMG and CGB builds. It implements DIV/TIMA/TMA/TAC with fully synchronous falling-edge detection and the exact one-M-cycle TIMA overflow/reload window. In CGB mode it adds the KEY1 speed-switch register and suspends the system counter during STOP. It sits on the CPU I/O bus beside the interrupt controller and drives the timer IRQ line.

## Interface
- CNT_W, 14: system counter width; DIV = counter[CNT_W-1:CNT_W-8]; legal 14..16.
- CGB_MODE, 1: 1 enables KEY1 (FF4D), speed switch and STOP handling; 0 gives DMG behaviour (FF4D reads FF, writes ignored, stop_i only suspends).

Ports:
- clk  in  1  machine (M) clock
- reset  in  1  asynchronous, active-high system reset
- data_i  in  8  write data bus
- addr  in  16  register address
- wren  in  1  write strobe for addr
- stop_i  in  1  CPU is in STOP (level)
- data_o  out  8  read data for addr; FF for unmapped addresses
- irq_timer  out  1  one-cycle timer interrupt request pulse
- double_speed  out  1  current CGB speed; to clock generator

## Operation
- All state is on posedge clk; no negedge or derived-clock flops.
- Reset: counter=0, TIMA=TMA=TAC=0, KEY1 prepare=0, double_speed=0, irq_timer=0, reload state IDLE.
- System counter:
  - +1 per clk, except while stop_i=1, when it holds.
  - Cleared by any write to FF04; the written data is ignored.
  - Cleared on a speed switch.
- Tick select bit by TAC[1:0]: 00→bit7, 01→bit1, 10→bit3, 11→bit5.
- tick_in = selected bit & TAC[2]. It is registered as tick_prev.
- inc = tick_prev & ~tick_in. This is a falling edge of the AND, so these all increment TIMA:
  - a DIV clear while the selected bit is 1;
  - a TAC disable while the selected bit is 1;
  - a TAC frequency change that drops the selected bit.
- Reload states:
  - IDLE:
    - inc with TIMA=FF: TIMA←00, go to OVF.
    - Otherwise: TIMA←TIMA+1 on inc.
  - OVF (TIMA reads 00 this cycle):
    - CPU write to TIMA: TIMA←data_i, reload and IRQ cancelled, return to IDLE.
    - Otherwise: go to RELOAD.
    - An inc in OVF is dropped.
  - RELOAD (one cycle, entered from OVF):
    - TIMA←TMA, or data_i if TMA is written in this same cycle.
    - irq_timer=1 for this cycle only.
    - CPU writes to TIMA are ignored.
    - Next state is IDLE.
- TMA write: TMA←data_i in any state.
- TAC write: TAC←data_i; bits 7:3 read back as 1.
- KEY1 (CGB_MODE=1):
  - Write sets prepare←data_i[0].
  - Read returns {double_speed,6'h3F,prepare}.
  - On the first cycle stop_i rises with prepare=1: double_speed toggles, prepare←0, counter clears.
- Reads are combinational on addr:
  - FF04 DIV
  - FF05 TIMA
  - FF06 TMA
  - FF07 {5'h1F,TAC[2:0]}
  - FF4D KEY1

## Timing
- Write-to-read latency is 1 cycle: a value written at edge N is visible after edge N.
- Overflow sequence:
  - Edge of inc: TIMA=00.
  - Next edge: TIMA=TMA and irq_timer asserts.
  - The edge after that: irq_timer deasserts.
- irq_timer is never high for two consecutive cycles.
- Same-cycle priority on TIMA:
  1. RELOAD value
  2. CPU write
  3. increment
- A DIV write and inc in the same cycle: the counter clear wins; the edge detector uses the pre-clear tick_in.
- Counter wraps silently at 2^CNT_W−1 → 0.
- stop_i deasserting resumes counting on the next edge. tick_prev is held during STOP, so no spurious inc occurs.
- Reset mid-OVF/RELOAD: state returns to IDLE and no IRQ is issued.

## Structure
- Package gb_timer_pkg:
  - address localparams ADDR_DIV, ADDR_TIMA, ADDR_TMA, ADDR_TAC, ADDR_KEY1;
  - enum tima_state_e {IDLE, OVF, RELOAD};
  - tap-select function tac_tap(freq) returning the bit index.
- One sub-module, gb_timer_edge: registered falling-edge detector with hold input. It is reused for the stop_i rising edge via an inverted input.
- Expected size ~200 lines of RTL.

## Test plan
- TAC=05 (tap bit1), TIMA=FE, TMA=AB: count 8 cycles → TIMA FE→FF→00, then AB. irq_timer is high exactly 1 cycle, coincident with TIMA=AB.
- Overflow with a TIMA write of 0x33 during the OVF cycle → TIMA=33, and no irq for 10 cycles.
- Overflow with a TIMA write of 0x33 during RELOAD → TIMA=TMA; irq pulse occurs. Overflow with a TMA write of 0x77 during RELOAD → TIMA=77.
- TAC=04 (bit7), run until counter[7]=1, write FF04 → counter=0 and TIMA increments by exactly 1. Repeat with TAC write 00 → TIMA also +1.
- CGB_MODE=1: write FF4D=01, then read → 7F. Raise stop_i → double_speed=1, FF4D reads FE, DIV=00. Counter holds while stop_i=1.
- CGB_MODE=0: FF4D reads FF, stop_i has no speed effect. Reset asserted mid-RELOAD → all registers 00, irq_timer=0 asynchronously.
